pixel_window_3x3: RTL and testbench
===================================

# pixel_window_3x3

Streaming 3x3 neighbourhood generator that sits directly upstream of the anti-aliasing weighted-average stage. It accepts one raster-ordered RGB pixel per cycle and buffers two lines in on-chip RAM. For every pixel of the frame it emits the full 3x3 window centred on that pixel, so the averaging stage reads nine neighbours from registers instead of nine parallel pixel lookups. Out-of-frame neighbours are forced to zero (black).

## Interface
- H_ACTIVE, 1024: pixels per line (2..2047)
- V_ACTIVE, 768: lines per frame (2..1023)
- clk  input  1  pixel clock; all logic on rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  in_rgb valid this cycle
- in_ready  output  1  block accepts in_rgb when in_valid && in_ready
- in_sof  input  1  qualifies the accepted pixel as (0,0) of a new frame
- in_rgb  input  24  {r[23:16], g[15:8], b[7:0]}
- out_valid  output  1  window valid
- out_ready  input  1  downstream accepts window when out_valid && out_ready
- out_win  output  216  slot k = row*3+col (row 0 = y-1, col 0 = x-1) at bits [24k+23:24k]; slot 4 is the centre
- out_x  output  11  centre x
- out_y  output  10  centre y
- out_eof  output  1  high with the window for centre (H_ACTIVE-1, V_ACTIVE-1)

## Operation
- States:
  - IDLE: in_ready=1. Accepted pixels without in_sof are discarded. An accepted pixel with in_sof goes to FILL.
  - FILL: accepting pixels; no output yet.
  - RUN: each accepted pixel produces one window.
  - FLUSH: in_ready=0. The block injects zero pixels internally, one per cycle whenever the output is not stalled.
- Input counters in_col/in_row track the accepted position. Linear index n = in_row*H_ACTIVE + in_col.
- Two line buffers, each H_ACTIVE x 24, are addressed by in_col. Reading and writing the same address in one cycle returns the old data.
- A 3x3 register window shifts one column per accepted (or injected) pixel:
  - New column: {line_buf1[col], line_buf0[col], in_rgb}.
  - line_buf0 is rewritten with in_rgb; line_buf1 is rewritten with the old line_buf0 value.
- Accepting index n with n >= H_ACTIVE+1 produces the window for centre index n-(H_ACTIVE+1). FILL moves to RUN at n = H_ACTIVE+1.
- Accepting n = H_ACTIVE*V_ACTIVE-1 moves to FLUSH. FLUSH injects H_ACTIVE+1 zero pixels, emits the final H_ACTIVE+1 windows, then returns to IDLE.
- Border masking is applied at the output register:
  - centre x=0: slots 0,3,6 = 0
  - centre x=H_ACTIVE-1: slots 2,5,8 = 0
  - centre y=0: slots 0,1,2 = 0
  - centre y=V_ACTIVE-1: slots 6,7,8 = 0
- in_sof accepted in any state other than IDLE aborts the current frame:
  - out_valid is cleared and any pending window is dropped.
  - Counters restart with this pixel as (0,0) and the state becomes FILL.
  - Stale line-buffer contents never reach the output, because the top row is masked for y=0.
- in_ready = (state != FLUSH) && (!out_valid || out_ready).

## Timing
- Reset values: out_valid=0, out_win=0, out_x=0, out_y=0, out_eof=0, state=IDLE, counters=0. in_ready=1 once reset deasserts.
- Latency: the window for centre index c is registered and presented the cycle after input index c+H_ACTIVE+1 is accepted (or injected).
- Throughput: one window per cycle with no stall. A full frame takes H_ACTIVE*V_ACTIVE input cycles plus H_ACTIVE+1 flush cycles.
- Backpressure: while out_valid && !out_ready, out_* hold stable, no pixel is accepted and no injection advances.
- Reset asserted mid-frame clears all outputs and state on the same edge. Line-buffer RAM contents are not cleared.

## Test plan
- H=4,V=3; frame of pixels valued n+1 (in_rgb = 24'(n+1)), out_ready=1:
  - Exactly 12 windows, in order (0,0)..(3,2).
  - Centre (1,1) has slots 0..8 = 1,2,3,5,6,7,9,10,11.
  - Centre (0,0) has slots 0,1,2,3,6 = 0 and slot 4 = 1.
  - out_eof only on (3,2).
- Same frame: the first window appears 1 cycle after accepting index 5. in_ready=0 for exactly 5 flush cycles after index 11.
- Hold out_ready=0 for 3 cycles mid-frame: out_win/out_x/out_y are unchanged, in_ready=0 throughout, no pixel lost, and the window sequence is identical to the unstalled run.
- in_sof reasserted at index 7 of the first frame: no window from the aborted frame appears afterwards, and the new frame's windows match the reference values from scenario 1.
- Assert reset during RUN: the next edge gives out_valid=0, out_win=0 and state IDLE. Non-sof pixels are then dropped until in_sof arrives.
- H=2,V=2 minimum frame: 4 windows. Every window has all eight non-centre slots either the correct neighbour or 0 per the masking rules.

Source files
------------

// File: rtl/pixel_window_3x3.sv
// pixel_window_3x3
//
// Streaming 3x3 neighbourhood generator for raster-ordered RGB pixels.
// Two line buffers hold the previous two lines. A column-shifting register
// window then presents the full 3x3 neighbourhood of every pixel to the
// downstream averaging stage. Neighbours that fall outside the frame are
// forced to zero.
//
// Ports
//   clk        pixel clock, rising edge
//   reset      asynchronous, active-high
//   in_valid   in_rgb valid this cycle
//   in_ready   pixel accepted when in_valid && in_ready
//   in_sof     accepted pixel is (0,0) of a new frame (aborts any frame in progress)
//   in_rgb     {r, g, b}, 8 bits each
//   out_valid  window valid
//   out_ready  downstream accepts the window when out_valid && out_ready
//   out_win    nine 24-bit slots, slot k = row*3+col at [24k+23:24k], slot 4 = centre
//   out_x      centre x
//   out_y      centre y
//   out_eof    window belongs to the last pixel of the frame
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for in_sof; other accepted pixels are discarded
// ST_FILL  | first H_ACTIVE+1 pixels of a frame, no window available yet
// ST_RUN   | every accepted pixel produces one window
// ST_FLUSH | input closed, zero pixels injected to drain the last windows

module pixel_window_3x3 #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sof,
    input  logic [23:0]  in_rgb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [215:0] out_win,
    output logic [10:0]  out_x,
    output logic [9:0]   out_y,
    output logic         out_eof
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam int          AW         = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [10:0] COL_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  ROW_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [10:0] FLUSH_LOAD = 11'(H_ACTIVE);

    logic [1:0]  state;

    // Position of the next pixel to enter the window
    logic [10:0] in_col;
    logic [9:0]  in_row;

    // Position of the centre of the next window to be emitted
    logic [10:0] cen_col;
    logic [9:0]  cen_row;

    // Remaining zero injections minus one
    logic [10:0] flush_cnt;

    // Two rightmost window columns, index = row (0 = top)
    logic [2:0][23:0] col_mid;
    logic [2:0][23:0] col_right;
    logic [2:0][23:0] col_new;

    logic [8:0][23:0] win_next;
    logic [8:0][23:0] win_masked;

    logic [23:0] line_buf0 [H_ACTIVE];
    logic [23:0] line_buf1 [H_ACTIVE];

    logic [AW-1:0] buf_addr;
    logic [23:0]   lb0_rd;
    logic [23:0]   lb1_rd;
    logic [23:0]   px;

    logic out_free;
    logic accept;
    logic start;
    logic inject;
    logic step;
    logic emit;
    logic at_last_px;
    logic fill_done;

    // ------------------------------------------------------------------
    // Handshake and pixel qualification
    // ------------------------------------------------------------------
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state != ST_FLUSH) && out_free;
    assign accept   = in_valid && in_ready;
    assign start    = accept && in_sof;
    assign inject   = (state == ST_FLUSH) && out_free;

    // A pixel enters the window on a frame start, on any accepted frame
    // pixel, or on a flush injection.
    assign step = start || (accept && (state != ST_IDLE)) || inject;

    assign at_last_px = (in_col == COL_LAST) && (in_row == ROW_LAST);

    // Linear index of the incoming pixel is at least H_ACTIVE+1
    assign fill_done = (in_row > 10'd1) || ((in_row == 10'd1) && (in_col != 11'd0));

    always_comb begin
        emit = 1'b0;
        if (inject) begin
            emit = 1'b1;
        end else if (accept && !in_sof) begin
            case (state)
                ST_FILL: emit = fill_done;
                ST_RUN:  emit = 1'b1;
                default: emit = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line buffers
    // ------------------------------------------------------------------
    // A frame start always lands in column 0, whatever the counters held
    // from an aborted or completed frame.
    assign buf_addr = start ? '0 : in_col[AW-1:0];
    assign px       = inject ? 24'd0 : in_rgb;
    assign lb0_rd   = line_buf0[buf_addr];
    assign lb1_rd   = line_buf1[buf_addr];

    // Read-before-write: the window sees the old contents of this column.
    always_ff @(posedge clk) begin
        if (step) begin
            line_buf0[buf_addr] <= px;
            line_buf1[buf_addr] <= lb0_rd;
        end
    end

    // ------------------------------------------------------------------
    // Window assembly and border masking
    // ------------------------------------------------------------------
    always_comb begin
        col_new[0] = lb1_rd;
        col_new[1] = lb0_rd;
        col_new[2] = px;
        for (int r = 0; r < 3; r++) begin
            win_next[r*3 + 0] = col_mid[r];
            win_next[r*3 + 1] = col_right[r];
            win_next[r*3 + 2] = col_new[r];
        end
    end

    // The left column wraps from the previous line and the top row comes from
    // stale buffer contents at the frame start; masking hides both.
    always_comb begin
        win_masked = win_next;
        if (cen_col == 11'd0) begin
            win_masked[0] = 24'd0;
            win_masked[3] = 24'd0;
            win_masked[6] = 24'd0;
        end
        if (cen_col == COL_LAST) begin
            win_masked[2] = 24'd0;
            win_masked[5] = 24'd0;
            win_masked[8] = 24'd0;
        end
        if (cen_row == 10'd0) begin
            win_masked[0] = 24'd0;
            win_masked[1] = 24'd0;
            win_masked[2] = 24'd0;
        end
        if (cen_row == ROW_LAST) begin
            win_masked[6] = 24'd0;
            win_masked[7] = 24'd0;
            win_masked[8] = 24'd0;
        end
    end

    // ------------------------------------------------------------------
    // Control, counters and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_col    <= '0;
            in_row    <= '0;
            cen_col   <= '0;
            cen_row   <= '0;
            flush_cnt <= '0;
            col_mid   <= '0;
            col_right <= '0;
            out_valid <= 1'b0;
            out_win   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_eof   <= 1'b0;
        end else begin
            if (step) begin
                col_mid   <= col_right;
                col_right <= col_new;
            end

            if (start) begin
                // This pixel is (0,0); anything still pending belongs to the
                // abandoned frame.
                state     <= ST_FILL;
                in_col    <= 11'd1;
                in_row    <= '0;
                cen_col   <= '0;
                cen_row   <= '0;
                out_valid <= 1'b0;
            end else begin
                if (step) begin
                    if (in_col == COL_LAST) begin
                        in_col <= '0;
                        in_row <= in_row + 10'd1;
                    end else begin
                        in_col <= in_col + 11'd1;
                    end
                end

                case (state)
                    ST_FILL: begin
                        if (accept) begin
                            // The smallest frame reaches its last pixel on
                            // the same pixel that ends the fill.
                            if (at_last_px) begin
                                state     <= ST_FLUSH;
                                flush_cnt <= FLUSH_LOAD;
                            end else if (fill_done) begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (accept && at_last_px) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_LOAD;
                        end
                    end
                    ST_FLUSH: begin
                        if (inject) begin
                            if (flush_cnt == 11'd0) begin
                                state <= ST_IDLE;
                            end else begin
                                flush_cnt <= flush_cnt - 11'd1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase

                if (emit) begin
                    out_valid <= 1'b1;
                    out_win   <= win_masked;
                    out_x     <= cen_col;
                    out_y     <= cen_row;
                    out_eof   <= (cen_col == COL_LAST) && (cen_row == ROW_LAST);
                    if (cen_col == COL_LAST) begin
                        cen_col <= '0;
                        cen_row <= cen_row + 10'd1;
                    end else begin
                        cen_col <= cen_col + 11'd1;
                    end
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Self-checking bench for pixel_window_3x3 (4x3 and 2x2 frame instances).
module tb_pixel_window_3x3;

    typedef struct packed {
        logic [215:0] win;
        logic [10:0]  x;
        logic [9:0]   y;
        logic         eof;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [23:0] in_rgb = '0;
    logic in_sof = 1'b0;

    logic         in_valid4 = 1'b0, out_ready4 = 1'b1;
    logic         in_ready4, out_valid4, out_eof4;
    logic [215:0] out_win4;
    logic [10:0]  out_x4;
    logic [9:0]   out_y4;

    logic         in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic         in_ready2, out_valid2, out_eof2;
    logic [215:0] out_win2;
    logic [10:0]  out_x2;
    logic [9:0]   out_y2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int acc5 = 0;
    int first_valid4 = -1;
    int n_win4 = 0, n_win2 = 0, eof_cnt4 = 0, eof_cnt2 = 0;

    exp_t q4[$];
    exp_t q2[$];
    exp_t mon_e4, mon_e2;
    logic [215:0] cap4 [12];

    logic [215:0] s_win;
    logic [10:0]  s_x;
    logic [9:0]   s_y;
    logic         held_ok;

    pixel_window_3x3 #(.H_ACTIVE(4), .V_ACTIVE(3)) u4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_sof(in_sof), .in_rgb(in_rgb),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_win(out_win4),
        .out_x(out_x4), .out_y(out_y4), .out_eof(out_eof4)
    );

    pixel_window_3x3 #(.H_ACTIVE(2), .V_ACTIVE(2)) u2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_sof(in_sof), .in_rgb(in_rgb),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_win(out_win2),
        .out_x(out_x2), .out_y(out_y2), .out_eof(out_eof2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: run still active at time limit, required completion");
        $fatal(1);
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset && out_valid4 && first_valid4 < 0) first_valid4 = cyc;
        if (!reset && out_valid4 && out_ready4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL u4_unexpected_window: got x=%0d y=%0d, required no window", out_x4, out_y4);
            end else begin
                mon_e4 = q4.pop_front();
                if ({out_win4, out_x4, out_y4, out_eof4} !== mon_e4) begin
                    errors++;
                    $display("FAIL u4_window: got x=%0d y=%0d eof=%0b win=%h, required x=%0d y=%0d eof=%0b win=%h",
                             out_x4, out_y4, out_eof4, out_win4, mon_e4.x, mon_e4.y, mon_e4.eof, mon_e4.win);
                end
            end
            if (out_x4 < 11'd4 && out_y4 < 10'd3) cap4[int'(out_y4) * 4 + int'(out_x4)] = out_win4;
            n_win4++;
            if (out_eof4) eof_cnt4++;
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid2 && out_ready2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL u2_unexpected_window: got x=%0d y=%0d, required no window", out_x2, out_y2);
            end else begin
                mon_e2 = q2.pop_front();
                if ({out_win2, out_x2, out_y2, out_eof2} !== mon_e2) begin
                    errors++;
                    $display("FAIL u2_window: got x=%0d y=%0d eof=%0b win=%h, required x=%0d y=%0d eof=%0b win=%h",
                             out_x2, out_y2, out_eof2, out_win2, mon_e2.x, mon_e2.y, mon_e2.eof, mon_e2.win);
                end
            end
            n_win2++;
            if (out_eof2) eof_cnt2++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic chkw(input string name, input logic [215:0] act, input logic [215:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [215:0] w, input int x, input int y, input logic eof);
        exp_t e;
        e.win = w;
        e.x   = 11'(x);
        e.y   = 10'(y);
        e.eof = eof;
        return e;
    endfunction

    function automatic logic [215:0] w9(input int s0, input int s1, input int s2,
                                        input int s3, input int s4, input int s5,
                                        input int s6, input int s7, input int s8);
        logic [215:0] w;
        w = {24'(s8), 24'(s7), 24'(s6), 24'(s5), 24'(s4), 24'(s3), 24'(s2), 24'(s1), 24'(s0)};
        return w;
    endfunction

    // Reference for the 4x3 frame: pixel (x,y) has value off + y*4 + x.
    function automatic logic [215:0] model4(input int x, input int y, input int off);
        logic [215:0] w;
        int nx, ny;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            nx = x + (k % 3) - 1;
            ny = y + (k / 3) - 1;
            if (nx >= 0 && nx < 4 && ny >= 0 && ny < 3) w[24*k +: 24] = 24'(off + ny * 4 + nx);
        end
        return w;
    endfunction

    task automatic push4(input int off, input int c_first, input int c_last);
        for (int c = c_first; c <= c_last; c++)
            q4.push_back(mk(model4(c % 4, c / 4, off), c % 4, c / 4, (c == 11)));
    endtask

    task automatic send_px(input int which, input logic [23:0] rgb, input logic sof);
        int g;
        logic rdy;
        g = 0;
        rdy = 1'b0;
        in_rgb = rgb;
        in_sof = sof;
        if (which == 4) in_valid4 = 1'b1; else in_valid2 = 1'b1;
        while (!rdy && g < 200) begin
            @(negedge clk);
            rdy = (which == 4) ? in_ready4 : in_ready2;
            g++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        last_acc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_valid2 = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send4(input int off, input int n_first, input int n_last, input int sof_at);
        for (int n = n_first; n <= n_last; n++) begin
            send_px(4, 24'(off + n), (n == sof_at));
            if (n == 5) acc5 = last_acc;
        end
    endtask

    task automatic drain(input int which);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (((which == 4) ? (q4.size() != 0 || out_valid4) : (q2.size() != 0 || out_valid2)) && g < 200);
        if (which == 4) chk("u4_drain_queue_empty", 32'(q4.size()), 32'd0);
        else            chk("u2_drain_queue_empty", 32'(q2.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int fc;
    int nw;
    logic fdone;
    int ref11 [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid4), 32'd0);
        chkw("rst_out_win", out_win4, 216'd0);
        chk("rst_out_x", 32'(out_x4), 32'd0);
        chk("rst_out_y", 32'(out_y4), 32'd0);
        chk("rst_out_eof", 32'(out_eof4), 32'd0);
        chk("rst_in_ready", 32'(in_ready4), 32'd1);
        chk("rst_state_idle", 32'(u4.state), 32'd0);
        chk("rst_u2_out_valid", 32'(out_valid2), 32'd0);

        // Scenario 1: plain 4x3 frame, pixels n+1
        n_win4 = 0; eof_cnt4 = 0; first_valid4 = -1;
        push4(1, 0, 11);
        send4(1, 0, 11, 0);
        fc = 0; fdone = 1'b0;
        for (int g = 0; g < 50 && !fdone; g++) begin
            @(negedge clk);
            if (!in_ready4) fc++; else fdone = 1'b1;
        end
        chk("flush_ready_low_cycles", 32'(fc), 32'd5);
        drain(4);
        chk("first_window_latency", 32'(first_valid4), 32'(acc5));
        chk("s1_window_count", 32'(n_win4), 32'd12);
        chk("s1_eof_count", 32'(eof_cnt4), 32'd1);
        for (int k = 0; k < 9; k++)
            chk($sformatf("c11_slot%0d", k), 32'(cap4[5][24*k +: 24]), 32'(ref11[k]));
        chk("c00_slot0", 32'(cap4[0][0 +: 24]), 32'd0);
        chk("c00_slot1", 32'(cap4[0][24 +: 24]), 32'd0);
        chk("c00_slot2", 32'(cap4[0][48 +: 24]), 32'd0);
        chk("c00_slot3", 32'(cap4[0][72 +: 24]), 32'd0);
        chk("c00_slot4", 32'(cap4[0][96 +: 24]), 32'd1);
        chk("c00_slot6", 32'(cap4[0][144 +: 24]), 32'd0);

        // Scenario 2: 3-cycle output stall mid-frame
        n_win4 = 0; eof_cnt4 = 0;
        push4(1, 0, 11);
        fork
            send4(1, 0, 11, 0);
            begin
                for (int g = 0; g < 200 && n_win4 < 4; g++) @(negedge clk);
                @(posedge clk);
                #1 out_ready4 = 1'b0;
                @(negedge clk);
                s_win = out_win4; s_x = out_x4; s_y = out_y4;
                held_ok = out_valid4 && !in_ready4;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk);
                    if (out_win4 !== s_win || out_x4 !== s_x || out_y4 !== s_y || !out_valid4 || in_ready4)
                        held_ok = 1'b0;
                end
                chk("stall_outputs_held", 32'(held_ok), 32'd1);
                @(posedge clk);
                #1 out_ready4 = 1'b1;
            end
        join
        drain(4);
        chk("s2_window_count", 32'(n_win4), 32'd12);
        chk("s2_eof_count", 32'(eof_cnt4), 32'd1);

        // Scenario 3: in_sof at index 7 aborts and restarts
        n_win4 = 0; eof_cnt4 = 0;
        push4(32'h100000, 0, 1);
        push4(1, 0, 11);
        send4(32'h100000, 0, 6, 0);
        send4(1, 0, 11, 0);
        drain(4);
        chk("s3_window_count", 32'(n_win4), 32'd14);
        chk("s3_eof_count", 32'(eof_cnt4), 32'd1);

        // Scenario 4: reset during RUN with a window pending
        out_ready4 = 1'b0;
        send4(1, 0, 5, 0);
        @(negedge clk);
        chk("pre_reset_valid", 32'(out_valid4), 32'd1);
        chk("pre_reset_state_run", 32'(u4.state), 32'd2);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid4), 32'd0);
        chkw("mid_rst_out_win", out_win4, 216'd0);
        chk("mid_rst_out_x", 32'(out_x4), 32'd0);
        chk("mid_rst_state_idle", 32'(u4.state), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready4 = 1'b1;
        nw = n_win4;
        send_px(4, 24'h000055, 1'b0);
        send_px(4, 24'h000056, 1'b0);
        send_px(4, 24'h000057, 1'b0);
        @(negedge clk);
        chk("nosof_state_idle", 32'(u4.state), 32'd0);
        chk("nosof_no_window", 32'(n_win4), 32'(nw));
        chk("nosof_in_ready", 32'(in_ready4), 32'd1);
        n_win4 = 0; eof_cnt4 = 0;
        push4(1, 0, 11);
        send4(1, 0, 11, 0);
        drain(4);
        chk("s4_window_count", 32'(n_win4), 32'd12);

        // Scenario 5: 2x2 minimum frame, pixels 1..4
        q2.push_back(mk(w9(0, 0, 0, 0, 1, 2, 0, 3, 4), 0, 0, 1'b0));
        q2.push_back(mk(w9(0, 0, 0, 1, 2, 0, 3, 4, 0), 1, 0, 1'b0));
        q2.push_back(mk(w9(0, 1, 2, 0, 3, 4, 0, 0, 0), 0, 1, 1'b0));
        q2.push_back(mk(w9(1, 2, 0, 3, 4, 0, 0, 0, 0), 1, 1, 1'b1));
        send_px(2, 24'd1, 1'b1);
        send_px(2, 24'd2, 1'b0);
        send_px(2, 24'd3, 1'b0);
        send_px(2, 24'd4, 1'b0);
        drain(2);
        chk("u2_window_count", 32'(n_win2), 32'd4);
        chk("u2_eof_count", 32'(eof_cnt2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
